// File: rtl/aes_pkg.sv
// Shared AES field constants, basis-change matrices and
// GF(2^2)/GF(2^4) arithmetic for the composite-field S-box.
package aes_pkg;

  typedef logic [7:0] byte_t;
  typedef logic [3:0] nib_t;
  typedef logic [1:0] gf4_t;
  typedef logic [7:0][7:0] mat8_t;

  localparam byte_t AES_POLY     = 8'h1B;
  localparam byte_t INV_AFFINE_C = 8'h05;

  // GF(4)=GF(2)[x]/(x^2+x+1)
  // GF(16)=GF(4)[y]/(y^2+y+PHI)
  // GF(256)=GF(16)[z]/(z^2+z+LAMBDA)
  localparam gf4_t PHI    = 2'b10;
  localparam nib_t LAMBDA = 4'hC;

  // Row i = mask of source bits XORed into result bit i.
  // ISO_M: polynomial basis -> composite basis.
  localparam mat8_t ISO_M = {
    8'hA0, 8'hDE, 8'hAC, 8'hAE,
    8'hC6, 8'h9E, 8'h52, 8'h43
  };

  // ISO_INV_M: composite basis -> polynomial basis.
  localparam mat8_t ISO_INV_M = {
    8'hE2, 8'h44, 8'h62, 8'h76,
    8'h3E, 8'h9E, 8'h30, 8'h75
  };

  function automatic byte_t mat_mul(
    input mat8_t m,
    input byte_t x
  );
    byte_t r;
    for (int i = 0; i < 8; i++)
      r[i] = ^(m[i] & x);
    return r;
  endfunction

  function automatic gf4_t gf4_mul(
    input gf4_t a,
    input gf4_t b
  );
    gf4_t r;
    r[1] = (a[1] & b[1]) ^ (a[1] & b[0])
         ^ (a[0] & b[1]);
    r[0] = (a[1] & b[1]) ^ (a[0] & b[0]);
    return r;
  endfunction

  // In GF(4) the square is also the inverse.
  function automatic gf4_t gf4_sq(
    input gf4_t a
  );
    return {a[1], a[1] ^ a[0]};
  endfunction

  function automatic nib_t gf16_mul(
    input nib_t a,
    input nib_t b
  );
    gf4_t hh;
    gf4_t hl;
    gf4_t lh;
    gf4_t ll;
    hh = gf4_mul(a[3:2], b[3:2]);
    hl = gf4_mul(a[3:2], b[1:0]);
    lh = gf4_mul(a[1:0], b[3:2]);
    ll = gf4_mul(a[1:0], b[1:0]);
    return {hh ^ hl ^ lh,
            gf4_mul(hh, PHI) ^ ll};
  endfunction

  function automatic nib_t gf16_sq(
    input nib_t a
  );
    gf4_t h2;
    h2 = gf4_sq(a[3:2]);
    return {h2,
            gf4_mul(h2, PHI) ^ gf4_sq(a[1:0])};
  endfunction

  function automatic nib_t gf16_inv(
    input nib_t a
  );
    gf4_t ah;
    gf4_t al;
    gf4_t d;
    gf4_t di;
    ah = a[3:2];
    al = a[1:0];
    d  = gf4_mul(gf4_sq(ah), PHI)
       ^ gf4_mul(ah, al)
       ^ gf4_sq(al);
    di = gf4_sq(d);
    return {gf4_mul(ah, di),
            gf4_mul(ah ^ al, di)};
  endfunction

endpackage

// File: rtl/gf256_inv.sv
// Combinational GF(2^8) multiplicative inverse (0 -> 0)
// computed in the composite field GF((2^4)^2).
module gf256_inv
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  byte_t d;
  nib_t  ah;
  nib_t  al;
  nib_t  dn;
  nib_t  di;
  byte_t q;

  // Map to composite basis, invert, map back.
  always_comb begin
    d  = mat_mul(ISO_M, a);
    ah = d[7:4];
    al = d[3:0];
    dn = gf16_mul(LAMBDA, gf16_sq(ah))
       ^ gf16_mul(ah, al)
       ^ gf16_sq(al);
    di = gf16_inv(dn);
    q  = {gf16_mul(ah, di),
          gf16_mul(ah ^ al, di)};
    y  = mat_mul(ISO_INV_M, q);
  end

endmodule

// File: rtl/inv_sub_bytes.sv
// Single-byte AES inverse S-box with a registered output:
// inverse affine, composite-field inverse, then flop.
module inv_sub_bytes
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] state,
  output logic [7:0] Sstate
);

  byte_t aff;
  byte_t inv;

  // Inverse affine transform ahead of the field inverse.
  always_comb begin
    aff = '0;
    for (int i = 0; i < 8; i++)
      aff[i] = state[(i + 2) % 8]
             ^ state[(i + 5) % 8]
             ^ state[(i + 7) % 8]
             ^ INV_AFFINE_C[i];
  end

  gf256_inv u_inv (
    .a (aff),
    .y (inv)
  );

  // Output register, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      Sstate <= 8'h00;
    else
      Sstate <= inv;
  end

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Scoreboard bench for inv_sub_bytes: directed vectors,
// full sweep against a search-built S-box model, resets.
module tb_inv_sub_bytes;
  import aes_pkg::*;

  typedef struct {
    logic [7:0] exp;
    logic [7:0] orig;
    bit         rt;
  } item_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] state;
  logic [7:0] Sstate;
  logic       vld;

  item_t      q[$];
  logic [7:0] fwd  [256];
  logic [7:0] invt [256];
  int         checks;
  int         errors;

  inv_sub_bytes dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .state  (state),
    .Sstate (Sstate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ AES_POLY)
               : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_model();
    logic [7:0] s;
    logic [7:0] b;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      s = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01)
          s = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = s[i] ^ s[(i + 4) % 8]
             ^ s[(i + 5) % 8] ^ s[(i + 6) % 8]
             ^ s[(i + 7) % 8] ^ c[i];
      fwd[x]  = b;
      invt[b] = 8'(x);
    end
  endtask

  task automatic chk(
    input string      nm,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h",
               nm, act, exp);
    end
  endtask

  task automatic issue(
    input logic [7:0] x,
    input logic [7:0] e,
    input bit         rt
  );
    item_t it;
    @(negedge clk);
    state = x;
    vld   = 1'b1;
    it.exp  = e;
    it.orig = x;
    it.rt   = rt;
    q.push_back(it);
  endtask

  // Monitor: a byte presented before this edge is due #1 after it.
  always @(posedge clk) begin
    if (vld && rst_n) begin
      item_t it;
      #1;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got %02h expected none",
                 Sstate);
      end else begin
        it = q.pop_front();
        chk($sformatf("sstate[%02h]", it.orig),
            Sstate, it.exp);
        if (it.rt)
          chk($sformatf("roundtrip[%02h]", it.orig),
              fwd[Sstate], it.orig);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    vld    = 1'b0;
    state  = 8'hFF;
    build_model();

    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", Sstate, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", Sstate, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    issue(8'hFF, 8'h7D, 1'b0);
    issue(8'h00, 8'h52, 1'b0);
    issue(8'h01, 8'h09, 1'b0);
    issue(8'h02, 8'h6A, 1'b0);
    issue(8'hFF, 8'h7D, 1'b0);
    issue(8'h4F, 8'h92, 1'b0);
    issue(8'h63, 8'h00, 1'b0);

    issue(8'h00, 8'h52, 1'b0);
    issue(8'h01, 8'h09, 1'b0);
    issue(8'h02, 8'h6A, 1'b0);

    issue(8'h01, 8'h09, 1'b0);
    issue(8'h02, 8'h6A, 1'b0);
    #1 state = 8'h55;
    #1 state = 8'hAA;
    #1;
    chk("glitch_hold", Sstate, 8'h09);
    #1 state = 8'h02;

    for (int i = 0; i < 256; i++)
      issue(8'(i), invt[i], 1'b1);

    issue(8'h4F, 8'h92, 1'b0);
    issue(8'h4F, 8'h92, 1'b0);
    issue(8'h4F, 8'h92, 1'b0);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midstream_reset", Sstate, 8'h00);
    @(negedge clk);
    vld   = 1'b0;
    rst_n = 1'b1;
    issue(8'h02, 8'h6A, 1'b0);
    @(negedge clk);
    vld = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0",
               q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
